// File: rtl/pipo_reg_beh.sv
// Parallel-in parallel-out holding register with asynchronous active-low reset.
// Define PIPO_LOAD_EN to add a load enable; otherwise the word is captured on every clk edge.
module pipo_reg_beh #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPO_LOAD_EN
    input  logic             load,
`endif
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // Reset wins over any coincident clk edge; data_in only reaches data_out through the flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= RESET_VAL;
        end else begin
`ifdef PIPO_LOAD_EN
            if (load) begin
                data_out <= data_in;
            end
`else
            data_out <= data_in;
`endif
        end
    end

endmodule

// File: tb/tb_pipo_reg_beh.sv
// Directed self-checking bench for pipo_reg_beh (WIDTH=4, RESET_VAL=0).
// Covers reset, capture latency, async reset, edge isolation, load enable and reset priority.
module tb_pipo_reg_beh;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;

    int n_checks;
    int n_errors;
    logic [W-1:0] exp_q[$];

    pipo_reg_beh #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef PIPO_LOAD_EN
        .load    (load),
`endif
        .data_in (data_in),
        .data_out(data_out)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one word at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive_cycle(input logic [W-1:0] d, input logic ld);
        @(negedge clk);
        data_in = d;
        load    = ld;
        @(posedge clk);
        #1;
    endtask

    // Drive a word expected to be captured, then compare against the scoreboard head.
    task automatic capture(input string tag, input logic [W-1:0] d);
        exp_q.push_back(d);
        drive_cycle(d, 1'b1);
        check(tag, data_out, exp_q.pop_front());
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        load     = 1'b1;
        data_in  = 4'b1111;

        // T1: reset asserted asynchronously, held across two edges
        #2;
        rst = 1'b0;
        #1;
        check("t1_async_assert", data_out, 4'b0000);
        drive_cycle(4'b1111, 1'b1);
        check("t1_hold_edge1", data_out, 4'b0000);
        drive_cycle(4'b1111, 1'b1);
        check("t1_hold_edge2", data_out, 4'b0000);

        // T2: release at a falling edge; the next rising edge is the first capture
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(4'b1010);
        data_in = 4'b1010;
        @(posedge clk);
        #1;
        check("t2_cap_1010", data_out, exp_q.pop_front());
        capture("t2_cap_1100", 4'b1100);
        capture("t2_cap_0110", 4'b0110);

        // T3: reset asserted 2 ns after an edge clears data before the next edge
        #1;
        rst = 1'b0;
        #1;
        check("t3_async_clear", data_out, 4'b0000);
        drive_cycle(4'b0110, 1'b1);
        check("t3_hold_low", data_out, 4'b0000);

        // T4: data_in toggles between edges; only the value at the edge is taken
        @(negedge clk);
        rst     = 1'b1;
        data_in = 4'b0101;
        #2;
        data_in = 4'b0011;
        #1;
        check("t4_no_comb_path", data_out, 4'b0000);
        @(posedge clk);
        #1;
        check("t4_edge_value", data_out, 4'b0011);

`ifdef PIPO_LOAD_EN
        // T5: load=0 holds the last loaded word
        capture("t5_load_1001", 4'b1001);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b0111, 1'b0);
            check($sformatf("t5_hold_%0d", i), data_out, 4'b1001);
        end
`else
        // Without the load port every edge captures
        capture("t5_cap_1001", 4'b1001);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b0111, 1'b0);
            check($sformatf("t5_always_cap_%0d", i), data_out, 4'b0111);
        end
`endif

        // T6: reset asserted at the same edge that would capture 1111
        @(negedge clk);
        data_in = 4'b1111;
        load    = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        #1;
        check("t6_reset_priority", data_out, 4'b0000);
        drive_cycle(4'b1111, 1'b1);
        check("t6_hold_low", data_out, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        capture("t6_recover_0101", 4'b0101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
